// File: rtl/btn_debounce_bank_pkg.sv
// Shared configuration for the debounce bank: parameter defaults, legal
// ranges and the counter-width helper used by the per-channel qualifiers.
package btn_debounce_bank_pkg;

  localparam int unsigned N_DEF        = 5;
  localparam int unsigned N_MIN        = 1;
  localparam int unsigned N_MAX        = 32;

  localparam int unsigned SYNC_DEF     = 2;
  localparam int unsigned SYNC_MIN     = 2;
  localparam int unsigned SYNC_MAX     = 4;

  localparam int unsigned PRESCALE_DEF = 1000;
  localparam int unsigned PRESCALE_MIN = 1;
  localparam int unsigned PRESCALE_MAX = 65536;

  localparam int unsigned STABLE_DEF   = 10;
  localparam int unsigned STABLE_MIN   = 2;
  localparam int unsigned STABLE_MAX   = 65536;

  localparam logic        RESET_VAL_DEF = 1'b0;

  // Bits needed to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce_bank_tick_gen.sv
// Sample-strobe generator: one-cycle pulse every PRESCALE clocks, first pulse
// PRESCALE cycles after reset release; with PRESCALE=1 the strobe stays high.
module tick_gen
  import btn_debounce_bank_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned         PW   = cnt_width(PRESCALE);
  localparam logic [PW-1:0]       LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;
  logic          r_tick;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + PW'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/btn_debounce_bank.sv
// Bank of N independent button debouncers: synchroniser, shared sample tick,
// per-channel stability counter, and registered rise/fall edge pulses.
module btn_debounce_bank
  import btn_debounce_bank_pkg::*;
#(
  parameter int unsigned N           = N_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_DEF,
  parameter int unsigned PRESCALE    = PRESCALE_DEF,
  parameter int unsigned STABLE_CNT  = STABLE_DEF,
  parameter logic        RESET_VAL   = RESET_VAL_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         tick
);

  localparam int unsigned   CW       = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic w_tick;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign tick = w_tick;

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_out;
    logic                   r_out_d;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;
    logic                   w_diff;

    // NOTE: the synchroniser flops are reset to the debounced reset level so
    // a quiet input at RESET_VAL never looks like a pending transition.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= {SYNC_STAGES{RESET_VAL}};
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], in[gi]};
      end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_diff = w_s ^ r_out;

    // Any agreeing tick clears the count, so a glitch restarts qualification.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_out <= RESET_VAL;
      end else if (w_tick) begin
        if (!w_diff) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_out <= w_s;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end

    // Edge pulses come from the previous/current level of out, so reset
    // (which forces both to RESET_VAL together) can never create a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out_d <= RESET_VAL;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_out_d <= r_out;
        r_rise  <= r_out & ~r_out_d;
        r_fall  <= ~r_out & r_out_d;
      end
    end

    assign out[gi]  = r_out;
    assign rise[gi] = r_rise;
    assign fall[gi] = r_fall;
  end

endmodule

// File: doc/btn_debounce_bank.md
BTN_DEBOUNCE_BANK -- requirements
Module: btn_debounce_bank

Interface
REQ-001 Parameter N, default 5: number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flip-flops per channel (2..4).
REQ-003 Parameter PRESCALE, default 1000: clock cycles per sample tick (1..2^16).
REQ-004 Parameter STABLE_CNT, default 10: consecutive differing ticks required to accept a new level (2..2^16).
REQ-005 Parameter RESET_VAL, default 0: debounced level of every channel after reset.
REQ-006 clk  input  1  single system clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 in  input  N  raw asynchronous (bouncing) inputs.
REQ-009 out  output  N  debounced levels.
REQ-010 rise  output  N  one-cycle pulse when out[i] goes 0->1.
REQ-011 fall  output  N  one-cycle pulse when out[i] goes 1->0.
REQ-012 tick  output  1  one-cycle sample strobe, for observation and chaining.

Function
REQ-013 Each in[i] SHALL pass through SYNC_STAGES flip-flops before any other use; synchronised value s[i].
REQ-014 Tick generator SHALL assert tick for one cycle every PRESCALE cycles; with PRESCALE=1, tick SHALL be constantly 1.
REQ-015 Per channel, a counter of ceil(log2(STABLE_CNT)) bits SHALL be kept; all channels share tick.
REQ-016 On a tick cycle with s[i]==out[i], cnt[i] SHALL clear to 0.
REQ-017 On a tick cycle with s[i]!=out[i] and cnt[i]<STABLE_CNT-1, cnt[i] SHALL increment by 1.
REQ-018 On a tick cycle with s[i]!=out[i] and cnt[i]==STABLE_CNT-1, out[i] SHALL take s[i] on that edge and cnt[i] SHALL clear to 0.
REQ-019 On non-tick cycles cnt[i] and out[i] SHALL hold.
REQ-020 Counter SHALL never wrap; STABLE_CNT-1 is the maximum value held.
REQ-021 rise[i]/fall[i] SHALL be registered, asserting in the cycle after out[i] changes, for exactly one cycle; never both at once.
REQ-022 Any single tick with s[i]==out[i] SHALL restart the qualification (glitch rejection); no partial credit retained.
REQ-023 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each be handled in the same cycle.
REQ-024 Latency, PRESCALE=1, clean step: out[i] changes exactly SYNC_STAGES+STABLE_CNT edges after the first edge sampling the new in[i] level.

Reset
REQ-025 While rst_n=0: synchroniser flops and out = RESET_VAL replicated, cnt=0, rise=fall=0, prescaler counter=0, tick=0.
REQ-026 Reset assertion mid-qualification SHALL discard progress; no rise/fall pulse SHALL be produced by reset entry or release.
REQ-027 After release, first tick SHALL occur PRESCALE cycles later.

Structure
REQ-028 Shared package holds parameter defaults, range limits and a cnt-width function (clog2); no typedefs needed beyond these.
REQ-029 Sub-module tick_gen (parameter PRESCALE; ports clk, rst_n, tick) SHALL be instantiated once; per-channel logic via generate loop.

Verification
REQ-030 N=4, SYNC_STAGES=2, PRESCALE=1, STABLE_CNT=8: in[0] 0->1 held 20 cycles -> out[0]=1 exactly 10 cycles later; rise[0] one cycle after that; fall=0.
REQ-031 Same config: in[1] toggles every 3 cycles for 30 cycles then holds 1 -> out[1] stays 0 during bounce; single rise[1]; out[1]=1 10 cycles after last edge.
REQ-032 Same config: in[2] high for 7 cycles then low -> out[2], rise[2], fall[2] remain 0 throughout.
REQ-033 Same config: in[0] and in[3] rise on same edge, in[3] falls after 4 cycles -> out[0] rises at cycle 10, out[3] never changes.
REQ-034 Same config: in[0] high, rst_n low after 5 cycles for 2 cycles -> out=0, no pulses; out[0] rises 10 cycles after release.
REQ-035 PRESCALE=4, STABLE_CNT=8: clean step on in[0] -> out[0] changes 30..34 cycles after step; tick period exactly 4 cycles.
